// File: rtl/serial_subtractor16bit.sv
// serial_subtractor16bit
//   Bit-serial subtractor: diff = (A - B - Bin) mod 2^WIDTH, one bit per
//   clock, LSB first, behind a start/done handshake. An operation accepted
//   on one rising edge finishes WIDTH edges later; done is then high for a
//   single cycle, during which a new start is also accepted.
//
//   Optional build macro: SUB_OVF_FLAG_EN adds the ovf port (two's-complement
//   overflow of the subtraction). Without it the port and its logic are absent.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  one-cycle request; A, B, Bin sampled on the accepting edge
//   A, B   minuend / subtrahend (WIDTH bits)
//   Bin    borrow-in
//   busy   high while bits are being processed
//   done   one-cycle pulse when diff/Bout (and ovf) are valid
//   diff   result; holds until the next operation starts shifting
//   Bout   borrow-out, 1 iff A < B + Bin (unsigned)
//   ovf    signed overflow (SUB_OVF_FLAG_EN only)
module serial_subtractor16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bout
`ifdef SUB_OVF_FLAG_EN
  , output logic           ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic a_bit, b_bit, d_bit, r_nxt, last, accept;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    a_bit  = a_reg[0];
    b_bit  = b_reg[0];
    d_bit  = a_bit ^ b_bit ^ borrow;
    r_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    last   = (cnt == CW'(WIDTH - 1));
    accept = start && ((state == S_IDLE) || (state == S_DONE));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      Bout   <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg  <= A;
        b_reg  <= B;
        borrow <= Bin;
        cnt    <= '0;
      end else if (state == S_SHIFT) begin
        a_reg  <= a_reg >> 1;
        b_reg  <= b_reg >> 1;
        diff   <= {d_bit, diff[WIDTH-1:1]};
        borrow <= r_nxt;
        cnt    <= cnt + 1'b1;
        if (last) begin
          Bout <= r_nxt;
`ifdef SUB_OVF_FLAG_EN
          // On the last bit a_bit/b_bit are the operand MSBs and d_bit is
          // the result MSB, so the flag needs no extra operand storage.
          ovf  <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
`endif
        end
      end
    end
  end

endmodule
